// File: rtl/snake_pkg.sv
// snake_pkg: shared types, playfield geometry and direction helper for the snake controller
package snake_pkg;
  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;
  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
  localparam int CELL_PX = 20;
  localparam int GRID_W = 32;
  localparam int GRID_H = 24;
  localparam int START_X = 15;
  localparam int START_Y = 11;
  function automatic dir_t opposite(input dir_t d);
    return d == UP ? DOWN : d == DOWN ? UP : d == LEFT ? RIGHT : LEFT;
  endfunction
endpackage

// File: rtl/snake_body.sv
// snake_body: segment shift register, length and cell-match comparators
module snake_body
  import snake_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int INIT_LEN = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init,
  input  logic       step,
  input  logic       grow,
  input  logic [4:0] nx,
  input  logic [4:0] ny,
  input  logic [4:0] qx,
  input  logic [4:0] qy,
  output logic       hit_next,
  output logic       q_body,
  output logic       q_head,
  output logic [4:0] head_x,
  output logic [4:0] head_y,
  output logic [4:0] length
);
  logic [4:0] sx [MAX_LEN];
  logic [4:0] sy [MAX_LEN];
  logic [MAX_LEN-1:0] m_next, m_q;
  logic [4:0] lim;
  // A growing step keeps the tail, so the tail cell is only an obstacle when growing
  always_comb begin
    lim = grow ? length : length - 5'd1;
    m_next = '0;
    m_q = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      m_next[i] = sx[i] == nx && sy[i] == ny && 5'(i) < lim;
      m_q[i] = sx[i] == qx && sy[i] == qy && 5'(i) < length;
    end
  end
  assign hit_next = |m_next;
  assign q_body = |m_q;
  assign q_head = sx[0] == qx && sy[0] == qy;
  assign head_x = sx[0];
  assign head_y = sy[0];
  // Body reinitialises to a horizontal line left of the start cell, or shifts one cell per step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        sx[i] <= 5'(START_X - i);
        sy[i] <= 5'(START_Y);
      end
      length <= 5'(INIT_LEN);
    end else if (init || step) begin
      sx[0] <= init ? 5'(START_X) : nx;
      sy[0] <= init ? 5'(START_Y) : ny;
      for (int i = 1; i < MAX_LEN; i++) begin
        sx[i] <= init ? 5'(START_X - i) : sx[i-1];
        sy[i] <= init ? 5'(START_Y) : sy[i-1];
      end
      length <= init ? 5'(INIT_LEN) : length + {4'd0, grow};
    end
  end
endmodule

// File: rtl/snake_ctrl.sv
// snake_ctrl: game FSM, step timer, direction latch and per-pixel snake overlay
module snake_ctrl
  import snake_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int INIT_LEN = 3,
  parameter int FRAMES_PER_STEP = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        start,
  input  logic        grow,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic [11:0] px_x,
  input  logic [11:0] px_y,
  output logic        pix_snake,
  output logic        pix_head,
  output logic [4:0]  head_x,
  output logic [4:0]  head_y,
  output logic [4:0]  length,
  output logic        running,
  output logic        game_over
);
  localparam int FW = FRAMES_PER_STEP > 1 ? $clog2(FRAMES_PER_STEP) : 1;
  state_t state, state_nx;
  dir_t dir, pend, btn_dir;
  logic [FW-1:0] fcnt;
  logic grow_pending, btn_any, step, grow_eff, border, collide, init, advance;
  logic hit_next, q_body, q_head, in_rng;
  logic [4:0] nx, ny, qx, qy;
  assign btn_dir = btn_up ? UP : btn_down ? DOWN : btn_left ? LEFT : RIGHT;
  assign btn_any = btn_up | btn_down | btn_left | btn_right;
  assign step = state == RUN && frame_start && fcnt == FW'(FRAMES_PER_STEP - 1);
  assign grow_eff = (grow_pending || grow) && length < 5'(MAX_LEN);
  assign nx = head_x + (pend == RIGHT ? 5'd1 : pend == LEFT ? 5'h1f : 5'd0);
  assign ny = head_y + (pend == DOWN ? 5'd1 : pend == UP ? 5'h1f : 5'd0);
  assign border = nx == 5'd0 || nx == 5'(GRID_W - 1) || ny == 5'd0 || ny == 5'(GRID_H - 1);
  assign collide = step && (border || hit_next);
  assign init = start && state != RUN;
  assign advance = step && !collide;
  assign in_rng = px_x < 12'(GRID_W * CELL_PX) && px_y < 12'(GRID_H * CELL_PX);
  assign qx = 5'(px_x / 12'(CELL_PX));
  assign qy = 5'(px_y / 12'(CELL_PX));
  assign running = state == RUN;
  assign game_over = state == OVER;
  snake_body #(.MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN)) u_body (
    .clk(clk), .rst_n(rst_n), .init(init), .step(advance), .grow(grow_eff),
    .nx(nx), .ny(ny), .qx(qx), .qy(qy), .hit_next(hit_next), .q_body(q_body),
    .q_head(q_head), .head_x(head_x), .head_y(head_y), .length(length)
  );
  // Next state: start leaves IDLE/OVER, a collision ends the game
  always_comb begin
    state_nx = init ? RUN : collide ? OVER : state;
  end
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // Frame timer, direction latch and pending grow request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt <= '0;
      dir <= RIGHT;
      pend <= RIGHT;
      grow_pending <= 1'b0;
    end else if (init) begin
      fcnt <= '0;
      dir <= RIGHT;
      pend <= RIGHT;
      grow_pending <= 1'b0;
    end else begin
      if (state == RUN && frame_start) fcnt <= step ? '0 : fcnt + 1'b1;
      if (step) dir <= pend;
      if (state == RUN && btn_any && btn_dir != opposite(dir)) pend <= btn_dir;
      grow_pending <= advance ? 1'b0 : grow_pending | grow;
    end
  end
  // Pixel overlay, one cycle behind the queried coordinate, blanked while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_snake <= 1'b0;
      pix_head <= 1'b0;
    end else begin
      pix_snake <= state != IDLE && in_rng && q_body;
      pix_head <= state != IDLE && in_rng && q_head;
    end
  end
endmodule
